lt24_stream_writer: RTL and testbench
=====================================

// Module: lt24_stream_writer
// PURPOSE
//  Parametrised write engine for the LT24 LCD 8080-style parallel bus. Accepts
//  command/data words over a valid/ready stream, buffers them in a FIFO and
//  replays them as timed CSX/DCX/WRX/DATA bus cycles. Also owns the LCD
//  power-up reset sequence and backlight enable. Sits between the Nios/DMA
//  pixel path and the LT24 pins in the system top.
// PARAMETERS
//  DATA_W          16       bus/data width (8 or 16)
//  FIFO_DEPTH      16       input FIFO entries; power of 2, >= 2
//  WR_LOW_CYCLES   2        clocks WRX held low per write (>= 1)
//  WR_HIGH_CYCLES  2        clocks WRX held high per write (>= 1)
//  RST_LOW_CYCLES  50000    clocks lcd_reset_n held low (1 ms @ 50 MHz)
//  RST_WAIT_CYCLES 6000000  clocks after lcd_reset_n rises before first write
// PORTS
//  clk          in   1                    system clock
//  reset        in   1                    synchronous, active-high reset
//  in_valid     in   1                    stream word valid
//  in_ready     out  1                    = !fifo_full && !reset
//  in_data      in   DATA_W               word to write
//  in_dcx       in   1                    0 = command, 1 = data
//  lcd_reset_req in  1                    1-cycle pulse: rerun LCD reset sequence
//  backlight_en in   1                    backlight request
//  init_done    out  1                    reset/wait sequence complete
//  busy         out  1                    FSM not IDLE or FIFO non-empty
//  fifo_level   out  $clog2(FIFO_DEPTH)+1 current FIFO occupancy
//  lcd_reset_n  out  1                    LCD reset pin
//  lcd_on       out  1                    backlight pin (backlight_en, 1 clk reg)
//  csx          out  1                    chip select, active low
//  dcx          out  1                    data/command select
//  wrx          out  1                    write strobe, LCD latches on rising edge
//  rdx          out  1                    read strobe, constant 1 (write-only)
//  data_out     out  DATA_W               bus data
// BEHAVIOUR
//  Reset values: lcd_reset_n=0, lcd_on=0, csx=1, wrx=1, rdx=1, dcx=1,
//   data_out=0, init_done=0, busy=0, fifo_level=0, FIFO emptied, FSM RST_LOW.
//  All pin outputs registered. Counters 32-bit, compare against PARAM-1.
//  FSM: RST_LOW -> (RST_LOW_CYCLES clks) RST_WAIT, lcd_reset_n=1
//   RST_WAIT -> (RST_WAIT_CYCLES clks) IDLE, init_done=1
//   IDLE: pending reset req && FIFO empty -> RST_LOW (init_done=0);
//         else FIFO non-empty -> pop, WR_LOW
//   WR_LOW: csx=0, wrx=0, dcx/data_out = popped word; after WR_LOW_CYCLES
//         -> WR_HIGH
//   WR_HIGH: wrx=1, csx=0, data/dcx held; after WR_HIGH_CYCLES: FIFO
//         non-empty and no pending reset req -> pop, WR_LOW (csx stays 0);
//         else -> IDLE, csx=1.
//  Latency: word accepted on edge E into empty FIFO with FSM IDLE -> csx/wrx
//   fall and data_out valid after edge E+1. Burst throughput: one word per
//   WR_LOW_CYCLES+WR_HIGH_CYCLES clks, CSX continuously low.
//  FIFO: push when in_valid&&in_ready; pop only by FSM. Simultaneous push+pop
//   legal, level unchanged; push when full impossible (in_ready=0). Words
//   accepted during RST_LOW/RST_WAIT are held and written after init_done.
//   Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
//  lcd_reset_req: sticky pending flag, honoured only in IDLE with FIFO empty;
//   cleared on entry to RST_LOW. Request during RST_* restarts nothing extra.
//  reset asserted mid-write: next edge forces all reset values (bus cycle
//   aborted, FIFO flushed), sequence restarts from RST_LOW.
//  data_out never changes while wrx=0 or within a WR_HIGH phase.
// TESTING (RST_LOW_CYCLES=4, RST_WAIT_CYCLES=8, FIFO_DEPTH=4, WR_*=2)
//  Release reset -> lcd_reset_n=0 for 4 clks then 1; init_done=1 8 clks later;
//   csx=wrx=rdx=1 throughout.
//  After init push 0x002C dcx=0 -> next edge csx=0,dcx=0,data_out=0x002C,
//   wrx low 2 clks, high 2 clks, then csx=1, busy=0.
//  Push 16 data words 0x0001..0x0010 held valid -> in_ready drops at level 4;
//   16 wrx rising edges, period 4 clks, csx low throughout, order preserved.
//  Push 3 words during RST_WAIT -> level=3, no wrx activity until init_done,
//   then 3 writes back-to-back.
//  Assert reset during WR_LOW of word 2 of 4 -> next edge csx=1,wrx=1,
//   data_out=0, fifo_level=0, lcd_reset_n=0.
//  Pulse lcd_reset_req with 2 words queued -> both written first, then
//   lcd_reset_n=0 for 4 clks, init_done low until wait completes.

Source files
------------

// File: rtl/lt24_stream_writer_if.sv
// Valid/ready stream carrying command/data words into the LT24 write engine.
`timescale 1ns/1ps
interface lt24_stream_writer_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_dcx;

  modport master (
    output in_valid,
    output in_data,
    output in_dcx,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dcx,
    output in_ready
  );
endinterface

// File: rtl/lt24_stream_writer.sv
// LT24 8080-style write engine: stream FIFO, timed CSX/WRX bus cycles,
// LCD power-up reset sequencing and backlight register.
`timescale 1ns/1ps
module lt24_stream_writer #(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned WR_LOW_CYCLES   = 2,
  parameter int unsigned WR_HIGH_CYCLES  = 2,
  parameter int unsigned RST_LOW_CYCLES  = 50000,
  parameter int unsigned RST_WAIT_CYCLES = 6000000
) (
  input  logic                            clk,
  input  logic                            reset,
  lt24_stream_writer_if.slave             stream,
  input  logic                            lcd_reset_req,
  input  logic                            backlight_en,
  output logic                            init_done,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            lcd_reset_n,
  output logic                            lcd_on,
  output logic                            csx,
  output logic                            dcx,
  output logic                            wrx,
  output logic                            rdx,
  output logic [DATA_W-1:0]               data_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [31:0] RstLowLast  = 32'(RST_LOW_CYCLES - 1);
  localparam logic [31:0] RstWaitLast = 32'(RST_WAIT_CYCLES - 1);
  localparam logic [31:0] WrLowLast   = 32'(WR_LOW_CYCLES - 1);
  localparam logic [31:0] WrHighLast  = 32'(WR_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    StRstLow,
    StRstWait,
    StIdle,
    StWrLow,
    StWrHigh
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                lcd_reset_n_q, lcd_reset_n_d;
  logic                init_done_q, init_done_d;
  logic                csx_q, csx_d;
  logic                wrx_q, wrx_d;
  logic                dcx_q, dcx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                lcd_on_q;

  // FIFO entries hold {dcx, data}.
  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     level_q, level_d;
  logic                fifo_empty, fifo_full;
  logic                push, pop;
  logic [DATA_W:0]     head;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
  assign push       = stream.in_valid && stream.in_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    lcd_reset_n_d = lcd_reset_n_q;
    init_done_d   = init_done_q;
    csx_d         = csx_q;
    wrx_d         = wrx_q;
    dcx_d         = dcx_q;
    data_d        = data_q;
    pop           = 1'b0;
    // Requests arriving while a reset sequence is already running are dropped.
    pend_d        = pend_q || (lcd_reset_req && (state_q != StRstLow) && (state_q != StRstWait));

    unique case (state_q)
      StRstLow: begin
        if (cnt_q == RstLowLast) begin
          state_d       = StRstWait;
          cnt_d         = '0;
          lcd_reset_n_d = 1'b1;
        end
      end
      StRstWait: begin
        if (cnt_q == RstWaitLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (pend_q && fifo_empty) begin
          state_d       = StRstLow;
          lcd_reset_n_d = 1'b0;
          init_done_d   = 1'b0;
          pend_d        = 1'b0;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StWrLow;
          csx_d   = 1'b0;
          wrx_d   = 1'b0;
          dcx_d   = head[DATA_W];
          data_d  = head[DATA_W-1:0];
        end
      end
      StWrLow: begin
        if (cnt_q == WrLowLast) begin
          state_d = StWrHigh;
          cnt_d   = '0;
          wrx_d   = 1'b1;
        end
      end
      StWrHigh: begin
        if (cnt_q == WrHighLast) begin
          cnt_d = '0;
          if (!fifo_empty && !pend_q) begin
            pop     = 1'b1;
            state_d = StWrLow;
            wrx_d   = 1'b0;
            dcx_d   = head[DATA_W];
            data_d  = head[DATA_W-1:0];
          end else begin
            state_d = StIdle;
            csx_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = StRstLow;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRstLow;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      lcd_reset_n_q <= 1'b0;
      init_done_q   <= 1'b0;
      csx_q         <= 1'b1;
      wrx_q         <= 1'b1;
      dcx_q         <= 1'b1;
      data_q        <= '0;
      lcd_on_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      lcd_reset_n_q <= lcd_reset_n_d;
      init_done_q   <= init_done_d;
      csx_q         <= csx_d;
      wrx_q         <= wrx_d;
      dcx_q         <= dcx_d;
      data_q        <= data_d;
      lcd_on_q      <= backlight_en;
      level_q       <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {stream.in_dcx, stream.in_data};
  end

  assign stream.in_ready = !fifo_full && !reset;
  assign busy            = !reset && ((state_q != StIdle) || !fifo_empty);
  assign fifo_level      = level_q;
  assign init_done       = init_done_q;
  assign lcd_reset_n     = lcd_reset_n_q;
  assign lcd_on          = lcd_on_q;
  assign csx             = csx_q;
  assign dcx             = dcx_q;
  assign wrx             = wrx_q;
  assign rdx             = 1'b1;
  assign data_out        = data_q;

endmodule

// File: tb/tb_lt24_stream_writer.sv
// Randomized bench for lt24_stream_writer: scoreboard of accepted words versus
// words latched on WRX rising edges, plus directed timing checks.
`timescale 1ns/1ps
module tb_lt24_stream_writer;

  localparam int unsigned DataW   = 16;
  localparam int unsigned Depth   = 4;
  localparam int unsigned WrLow   = 2;
  localparam int unsigned WrHigh  = 2;
  localparam int unsigned RstLow  = 4;
  localparam int unsigned RstWait = 8;
  localparam int unsigned LvlW    = $clog2(Depth) + 1;
  localparam time         ClkPer  = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lcd_reset_req = 1'b0;
  logic             backlight_en = 1'b0;
  logic             init_done, busy, lcd_reset_n, lcd_on, csx, dcx, wrx, rdx;
  logic [LvlW-1:0]  fifo_level;
  logic [DataW-1:0] data_out;

  lt24_stream_writer_if #(.DATA_W(DataW)) stream_if ();

  lt24_stream_writer #(
    .DATA_W          (DataW),
    .FIFO_DEPTH      (Depth),
    .WR_LOW_CYCLES   (WrLow),
    .WR_HIGH_CYCLES  (WrHigh),
    .RST_LOW_CYCLES  (RstLow),
    .RST_WAIT_CYCLES (RstWait)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stream        (stream_if),
    .lcd_reset_req (lcd_reset_req),
    .backlight_en  (backlight_en),
    .init_done     (init_done),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .lcd_reset_n   (lcd_reset_n),
    .lcd_on        (lcd_on),
    .csx           (csx),
    .dcx           (dcx),
    .wrx           (wrx),
    .rdx           (rdx),
    .data_out      (data_out)
  );

  always #(ClkPer / 2) clk = ~clk;

  int             n_checks = 0;
  int             n_fail = 0;
  logic [DataW:0] exp_q [$];
  int             wr_count = 0;
  int             csx_falls = 0;
  time            rise_t [$];
  logic           prev_wrx = 1'b1;
  logic           prev_csx = 1'b1;
  logic [DataW:0] fall_word = '0;
  int             max_level = 0;
  bit             saw_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // LCD model: a write is whatever sits on DCX/DATA at a WRX rising edge
  // while the panel is out of reset.
  always @(negedge clk) begin
    if (prev_wrx && !wrx) fall_word = {dcx, data_out};
    if (!prev_wrx && wrx && lcd_reset_n) begin
      wr_count++;
      rise_t.push_back($time);
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("wr_word", 32'({dcx, data_out}), 32'(exp_q.pop_front()));
      check("wr_hold", 32'({dcx, data_out}), 32'(fall_word));
      check("wr_csx", 32'(csx), 32'd0);
    end
    if (prev_csx && !csx) csx_falls++;
    prev_wrx = wrx;
    prev_csx = csx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (stream_if.in_valid && !stream_if.in_ready && fifo_level == LvlW'(Depth)) saw_full = 1'b1;
  endtask

  // Leaves in_valid asserted so consecutive calls form a continuous burst.
  task automatic push_word(input logic [DataW-1:0] d, input logic c);
    bit acc;
    int n = 0;
    stream_if.in_valid = 1'b1;
    stream_if.in_data  = d;
    stream_if.in_dcx   = c;
    do begin
      acc = stream_if.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    check("push_accept", 32'(acc), 32'd1);
    if (acc) exp_q.push_back({c, d});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !csx) && n < 600) begin
      tick();
      n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Starts just after the edge that entered the reset-low phase.
  task automatic measure_reset_seq();
    int n = 0;
    int m = 0;
    bit bad = 1'b0;
    while (!lcd_reset_n && n < 100) begin
      if (!csx || !wrx || !rdx || init_done) bad = 1'b1;
      tick();
      n++;
    end
    check("rst_low_clks", 32'(n), 32'(RstLow));
    while (!init_done && m < 100) begin
      if (!csx || !wrx || !rdx || !lcd_reset_n) bad = 1'b1;
      tick();
      m++;
    end
    check("rst_wait_clks", 32'(m), 32'(RstWait));
    check("rst_pins_idle", 32'(bad), 32'd0);
  endtask

  initial begin
    #(ClkPer * 40000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, falls0, n, w, h, low, pushes, bad_per;
    logic bl;

    stream_if.in_valid = 1'b0;
    stream_if.in_data  = '0;
    stream_if.in_dcx   = 1'b0;
    repeat (3) tick();

    check("rst_lcd_reset_n", 32'(lcd_reset_n), 32'd0);
    check("rst_lcd_on", 32'(lcd_on), 32'd0);
    check("rst_csx", 32'(csx), 32'd1);
    check("rst_wrx", 32'(wrx), 32'd1);
    check("rst_rdx", 32'(rdx), 32'd1);
    check("rst_dcx", 32'(dcx), 32'd1);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(stream_if.in_ready), 32'd0);

    reset = 1'b0;
    measure_reset_seq();

    // Single command word: latency, strobe widths, return to idle.
    base = wr_count;
    push_word(16'h002C, 1'b0);
    stream_if.in_valid = 1'b0;
    check("cmd_csx_e0", 32'(csx), 32'd1);
    tick();
    check("cmd_csx", 32'(csx), 32'd0);
    check("cmd_wrx", 32'(wrx), 32'd0);
    check("cmd_dcx", 32'(dcx), 32'd0);
    check("cmd_data", 32'(data_out), 32'h002C);
    w = 0;
    while (!wrx && w < 20) begin tick(); w++; end
    check("cmd_wrx_low", 32'(w), 32'(WrLow));
    h = 0;
    while (!csx && h < 20) begin tick(); h++; end
    check("cmd_wrx_high", 32'(h), 32'(WrHigh));
    check("cmd_busy", 32'(busy), 32'd0);
    check("cmd_writes", 32'(wr_count - base), 32'd1);

    // 16-word burst with in_valid held: back-pressure, period, CSX held low.
    base = wr_count;
    falls0 = csx_falls;
    rise_t.delete();
    max_level = 0;
    saw_full = 1'b0;
    for (int i = 1; i <= 16; i++) push_word(16'(i), 1'b1);
    stream_if.in_valid = 1'b0;
    wait_idle();
    check("burst_writes", 32'(wr_count - base), 32'd16);
    check("burst_csx_falls", 32'(csx_falls - falls0), 32'd1);
    check("burst_max_level", 32'(max_level), 32'(Depth));
    check("burst_saw_full", 32'(saw_full), 32'd1);
    bad_per = 0;
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != ClkPer * (WrLow + WrHigh)) bad_per++;
    check("burst_period", 32'(bad_per), 32'd0);

    // Words queued during the wait phase are held until init completes.
    lcd_reset_req = 1'b1;
    tick();
    lcd_reset_req = 1'b0;
    n = 0;
    while (lcd_reset_n && n < 20) begin tick(); n++; end
    check("req_enter_low", 32'(lcd_reset_n), 32'd0);
    n = 0;
    while (!lcd_reset_n && n < 20) begin tick(); n++; end
    check("wait_init_low", 32'(init_done), 32'd0);
    base = wr_count;
    falls0 = csx_falls;
    for (int i = 0; i < 3; i++) push_word(16'($urandom), 1'($urandom));
    stream_if.in_valid = 1'b0;
    check("wait_level", 32'(fifo_level), 32'd3);
    low = 0;
    n = 0;
    while (!init_done && n < 50) begin
      if (!wrx) low++;
      tick();
      n++;
    end
    check("wait_no_wrx", 32'(low), 32'd0);
    wait_idle();
    check("wait_writes", 32'(wr_count - base), 32'd3);
    check("wait_csx_falls", 32'(csx_falls - falls0), 32'd1);

    // Reset asserted during WR_LOW of the second of four words.
    base = wr_count;
    for (int i = 0; i < 4; i++) push_word(16'($urandom), 1'($urandom));
    stream_if.in_valid = 1'b0;
    n = 0;
    while (!(wr_count == base + 1 && !wrx) && n < 100) begin tick(); n++; end
    check("abort_in_wr2", 32'(wrx), 32'd0);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("abort_csx", 32'(csx), 32'd1);
    check("abort_wrx", 32'(wrx), 32'd1);
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_lcd_reset_n", 32'(lcd_reset_n), 32'd0);
    check("abort_writes", 32'(wr_count - base), 32'd1);
    reset = 1'b0;
    measure_reset_seq();

    // Reset request with two words queued: words first, then the sequence.
    base = wr_count;
    push_word(16'hA5A5, 1'b1);
    push_word(16'h5A5A, 1'b0);
    stream_if.in_valid = 1'b0;
    lcd_reset_req = 1'b1;
    tick();
    lcd_reset_req = 1'b0;
    n = 0;
    while (lcd_reset_n && n < 100) begin tick(); n++; end
    check("req2_writes", 32'(wr_count - base), 32'd2);
    check("req2_queue", 32'(exp_q.size()), 32'd0);
    check("req2_init_low", 32'(init_done), 32'd0);
    measure_reset_seq();

    // Randomized traffic, backlight and occasional reset requests.
    base = wr_count;
    pushes = 0;
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        int k;
        k = $urandom_range(1, 4);
        for (int j = 0; j < k; j++) push_word(16'($urandom), 1'($urandom));
        stream_if.in_valid = 1'b0;
        pushes += k;
      end else if (r < 8) begin
        bl = 1'($urandom);
        backlight_en = bl;
        tick();
        check("backlight", 32'(lcd_on), 32'(bl));
      end else if (r == 8) begin
        repeat ($urandom_range(1, 6)) tick();
      end else begin
        lcd_reset_req = 1'b1;
        tick();
        lcd_reset_req = 1'b0;
      end
    end
    wait_idle();
    check("rand_writes", 32'(wr_count - base), 32'(pushes));
    check("rand_init_done", 32'(init_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
